// File: rtl/uart_cmd_ctrl_if.sv
// Byte-stream input and register-bank outputs of the UART command sequencer.
// The master side feeds received bytes; the slave side is the sequencer itself.
interface uart_cmd_ctrl_if #(
  parameter int NREG = 4
) ();
  logic [7:0]        rx_data;
  logic              rx_req;
  logic [8*NREG-1:0] regs;
  logic              wr_pulse;
  logic [7:0]        wr_addr;
  logic              busy;
  logic [7:0]        err_cnt;

  modport master (
    output rx_data, rx_req,
    input  regs, wr_pulse, wr_addr, busy, err_cnt
  );

  modport slave (
    input  rx_data, rx_req,
    output regs, wr_pulse, wr_addr, busy, err_cnt
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Parses SYNC/ADDR/DATA/CHK frames from the UART byte stream into a register bank.
// Malformed or stalled frames are dropped and counted in a saturating counter.
module uart_cmd_ctrl #(
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         NREG    = 4,
  parameter int         TIMEOUT = 23440
) (
  input  logic            clk,
  input  logic            rst,
  uart_cmd_ctrl_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, GET_ADDR, GET_DATA, GET_CHK} state_t;

  state_t            state_q;
  logic [TW-1:0]     timer_q;
  logic [7:0]        addr_q;
  logic [7:0]        data_q;
  logic [8*NREG-1:0] regs_q;
  logic              wr_pulse_q;
  logic [7:0]        wr_addr_q;
  logic              busy_q;
  logic [7:0]        err_cnt_q;

  logic timeout;
  logic frame_ok;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A byte arriving on the timeout cycle takes priority over the timeout.
  assign timeout  = (state_q != IDLE) && !bus.rx_req && (timer_q == TW'(TIMEOUT - 1));
  assign frame_ok = (bus.rx_data == 8'(addr_q + data_q)) && (int'(addr_q) < NREG);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      regs_q     <= '0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      busy_q     <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      wr_pulse_q <= 1'b0;

      if (bus.rx_req || state_q == IDLE || timeout)
        timer_q <= '0;
      else
        timer_q <= timer_q + 1'b1;

      if (timeout) begin
        state_q   <= IDLE;
        busy_q    <= 1'b0;
        err_cnt_q <= sat_inc(err_cnt_q);
      end else if (bus.rx_req) begin
        case (state_q)
          IDLE: begin
            if (bus.rx_data == SYNC) begin
              state_q <= GET_ADDR;
              busy_q  <= 1'b1;
            end
          end
          GET_ADDR: begin
            addr_q  <= bus.rx_data;
            state_q <= GET_DATA;
          end
          GET_DATA: begin
            data_q  <= bus.rx_data;
            state_q <= GET_CHK;
          end
          GET_CHK: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (frame_ok) begin
              for (int i = 0; i < NREG; i++)
                if (addr_q == 8'(i)) regs_q[8*i +: 8] <= data_q;
              wr_addr_q  <= addr_q;
              wr_pulse_q <= 1'b1;
            end else begin
              err_cnt_q <= sat_inc(err_cnt_q);
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.regs     = regs_q;
  assign bus.wr_pulse = wr_pulse_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.busy     = busy_q;
  assign bus.err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed-frame bench for uart_cmd_ctrl: expected writes go through a queue
// checked by an independent wr_pulse monitor; status is checked inline.
module tb_uart_cmd_ctrl;

  localparam int NREG    = 4;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_cmd_ctrl_if #(.NREG(NREG)) bus ();

  uart_cmd_ctrl #(
    .SYNC    (8'hA5),
    .NREG    (NREG),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] exp_regs [NREG];
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [8*NREG-1:0] exp_bus();
    logic [8*NREG-1:0] v;
    for (int i = 0; i < NREG; i++) v[8*i +: 8] = exp_regs[i];
    return v;
  endfunction

  // Monitor: every wr_pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.wr_pulse !== 1'b0) begin
      wr_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_wr_pulse: wr_pulse=%b wr_addr=%0h, expected no write", bus.wr_pulse, bus.wr_addr);
      end else begin
        e = exp_q.pop_front();
        if (bus.wr_addr === e.addr && bus.regs[8*e.addr[1:0] +: 8] === e.data)
          n_pass++;
        else
          $display("FAIL write_event: addr=%0h data=%0h, expected addr=%0h data=%0h",
                   bus.wr_addr, bus.regs[8*e.addr[1:0] +: 8], e.addr, e.data);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_req  = 1'b1;
    @(posedge clk); #1;
    bus.rx_req  = 1'b0;
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
    send(8'hA5); send(a); send(d); send(c);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input logic [7:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    exp_q.push_back(w);
    exp_regs[a[1:0]] = d;
  endtask

  initial begin
    bus.rx_data = 8'h00;
    bus.rx_req  = 1'b0;
    for (int i = 0; i < NREG; i++) exp_regs[i] = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regs",     bus.regs,     exp_bus());
    chk("rst_wr_pulse", bus.wr_pulse, 1'b0);
    chk("rst_wr_addr",  bus.wr_addr,  8'h00);
    chk("rst_busy",     bus.busy,     1'b0);
    chk("rst_err",      bus.err_cnt,  8'h00);
    #2 rst = 1'b1;
    @(posedge clk); #1;

    // Valid write A5,02,3C,3E
    send(8'hA5);
    chk("busy_in_frame", bus.busy, 1'b1);
    send(8'h02); send(8'h3C);
    expect_write(8'h02, 8'h3C);
    send(8'h3E);
    chk("valid_pulse",  bus.wr_pulse, 1'b1);
    chk("valid_addr",   bus.wr_addr,  8'h02);
    chk("valid_regs",   bus.regs,     exp_bus());
    chk("valid_err",    bus.err_cnt,  8'h00);
    chk("valid_busy",   bus.busy,     1'b0);
    idle(1);
    chk("pulse_one_cycle", bus.wr_pulse, 1'b0);

    // Bad checksum, then the corrected frame
    frame(8'h01, 8'h10, 8'h12);
    chk("badchk_err",  bus.err_cnt, 8'h01);
    chk("badchk_busy", bus.busy,    1'b0);
    chk("badchk_regs", bus.regs,    exp_bus());
    expect_write(8'h01, 8'h10);
    frame(8'h01, 8'h10, 8'h11);
    chk("fixed_regs",  bus.regs,    exp_bus());
    chk("fixed_err",   bus.err_cnt, 8'h01);

    // Address out of range with a correct checksum
    frame(8'h04, 8'h55, 8'h59);
    chk("oor_err",  bus.err_cnt, 8'h02);
    chk("oor_regs", bus.regs,    exp_bus());

    // Timeout: busy holds through cycle 15, drops after cycle 16
    send(8'hA5); send(8'h00);
    idle(TIMEOUT - 1);
    chk("to_busy_before", bus.busy, 1'b1);
    idle(1);
    chk("to_busy_after", bus.busy,    1'b0);
    chk("to_err",        bus.err_cnt, 8'h03);
    send(8'h77); send(8'h77);
    chk("to_ignore_busy", bus.busy,    1'b0);
    chk("to_ignore_err",  bus.err_cnt, 8'h03);

    // Byte landing exactly on the timeout cycle wins
    send(8'hA5); send(8'h00);
    idle(TIMEOUT - 1);
    send(8'h11);
    chk("to_edge_busy", bus.busy, 1'b1);
    expect_write(8'h00, 8'h11);
    send(8'h11);
    chk("to_edge_err",  bus.err_cnt, 8'h03);
    chk("to_edge_regs", bus.regs,    exp_bus());

    // Leading noise and back-to-back bytes
    expect_write(8'h03, 8'h01);
    send(8'hFF); send(8'h00); send(8'hA5); send(8'h03); send(8'h01); send(8'h04);
    chk("b2b_regs", bus.regs,    32'h01_3C_10_11);
    chk("b2b_err",  bus.err_cnt, 8'h03);
    idle(2);

    // Asynchronous reset mid-frame
    send(8'hA5); send(8'h01);
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < NREG; i++) exp_regs[i] = 8'h00;
    chk("arst_regs", bus.regs,    32'h0);
    chk("arst_err",  bus.err_cnt, 8'h00);
    chk("arst_busy", bus.busy,    1'b0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    expect_write(8'h01, 8'h22);
    frame(8'h01, 8'h22, 8'h23);
    chk("post_rst_regs", bus.regs, 32'h00_00_22_00);

    // Saturation of the dropped-frame counter
    for (int i = 0; i < 300; i++) frame(8'h00, 8'h00, 8'h01);
    chk("sat_err",  bus.err_cnt, 8'hFF);
    chk("sat_regs", bus.regs,    exp_bus());
    chk("sat_busy", bus.busy,    1'b0);

    idle(3);
    chk("writes_all_seen", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
